// File: rtl/scmp_bus_ctrl.sv
// SC/MP external bus controller: demuxes the ADS address cycle, runs req/ack
// memory transactions with optional wait states and stalls the core via cpu_ce.
module scmp_bus_ctrl #(
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ads_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_d_o,
  output logic [7:0]  cpu_d_i,
  output logic        cpu_ce,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [3:0]  flags,
  output logic        halt,
  input  logic        cont
);

  typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT, DONE, HALT} state_t;

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  d_i_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        req_q, we_q, halt_q;
  logic [3:0]  flags_q;
  logic        strobe;

  assign strobe    = !cpu_rd_n || !cpu_wr_n;
  // Core runs only in DONE while a strobe is pending; never while halted.
  assign cpu_ce    = (state_q != HALT) && !(strobe && (state_q != DONE));
  assign cpu_d_i   = d_i_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign flags     = flags_q;
  assign halt      = halt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_i_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      halt_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE, ADDR, DONE: begin
          if (!cpu_ads_n && cpu_ce) begin
            addr_q  <= {cpu_d_o[3:0], cpu_addr};
            flags_q <= cpu_d_o[7:4];
            state_q <= ADDR;
          end else if (strobe && state_q != DONE) begin
            // Read wins when both strobes are low.
            req_q   <= 1'b1;
            we_q    <= cpu_rd_n;
            if (cpu_rd_n) wdata_q <= cpu_d_o;
            state_q <= REQ;
          end else if (state_q == DONE) begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          if (mem_ack) begin
            req_q <= 1'b0;
            if (!we_q) d_i_q <= mem_rdata;
            if (WAIT_STATES > 0) begin
              cnt_q   <= WS_LOAD;
              state_q <= WAIT;
            end else if (flags_q[3]) begin
              halt_q  <= 1'b1;
              state_q <= HALT;
            end else begin
              state_q <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            if (flags_q[3]) begin
              halt_q  <= 1'b1;
              state_q <= HALT;
            end else begin
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HALT: begin
          if (cont) begin
            halt_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scmp_bus_ctrl.md
# scmp_bus_ctrl

External bus controller sitting directly downstream of the SC/MP core. It demultiplexes the core's address-strobe cycle (A15:12 plus status flags on D_o during ADS_n) into a full 16-bit address, runs each read/write as a req/ack transaction with optional wait states, and stalls the core through a clock-enable until data is ready. It also implements the halt (F_H) handshake with an external continue input.

## Interface
- WAIT_STATES, 0: extra cycles inserted after mem_ack before the access completes (0..15).
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cpu_ads_n  in  1  core address strobe
- cpu_rd_n  in  1  core read strobe
- cpu_wr_n  in  1  core write strobe
- cpu_addr  in  12  core address A11:0
- cpu_d_o  in  8  core data out; {F_H,F_D,F_I,F_R,A15:12} while ADS_n low
- cpu_d_i  out  8  read data to core
- cpu_ce  out  1  core clock enable; 0 stalls the core
- mem_addr  out  16  latched bus address
- mem_wdata  out  8  write data
- mem_req  out  1  transaction request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_ack  in  1  single-cycle completion; read data valid on mem_rdata same cycle
- mem_rdata  in  8  read data
- flags  out  4  latched {F_H,F_D,F_I,F_R}
- halt  out  1  core halted awaiting cont
- cont  in  1  release from halt

## Operation
- States: IDLE, ADDR, REQ, WAIT, DONE, HALT.
- Address phase: any state except REQ/WAIT/HALT, cpu_ads_n=0 and cpu_ce=1 at posedge: mem_addr <= {cpu_d_o[3:0], cpu_addr}; flags <= cpu_d_o[7:4]; state -> ADDR. Repeated ADS relatches (last wins).
- ADDR, cpu_rd_n=0: mem_req<=1, mem_we<=0, -> REQ. cpu_wr_n=0 (rd_n high): mem_wdata<=cpu_d_o, mem_req<=1, mem_we<=1, -> REQ. Both low: read wins, no write issued.
- RD/WR strobe in IDLE (no preceding ADS): access issued using the currently held mem_addr.
- REQ, mem_ack=1: mem_req<=0; on read cpu_d_i<=mem_rdata; -> WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1), else DONE (or HALT, see below). mem_ack outside REQ ignored.
- WAIT: counter decrements each cycle; at 0 -> DONE/HALT.
- Completion with flags[3] (F_H)=1: -> HALT, halt<=1. HALT, cont=1 at posedge: halt<=0 -> DONE.
- DONE: one cycle with cpu_ce=1; core consumes cpu_d_i/advances; -> IDLE.
- cpu_ce (combinational) = 0 when (cpu_rd_n=0 or cpu_wr_n=0) and state != DONE; otherwise 1. Also 0 throughout HALT.
- cpu_d_i holds its value until the next read completes.

## Timing
- Reset values: state IDLE, mem_addr 0, mem_wdata 0, mem_req 0, mem_we 0, cpu_d_i 0, flags 0, halt 0, counter 0; cpu_ce=1 (strobes inactive).
- Reset mid-transaction: mem_req drops asynchronously; in-flight ack after reset ignored.
- Strobe asserted at edge N (state ADDR): mem_req high from N+1; ack sampled at edge N+1+k; DONE during cycle after; with WAIT_STATES=W, DONE is W cycles later.
- Minimum stall for zero-wait access with immediate ack: cpu_ce low for 2 cycles, high in DONE (3rd cycle).
- mem_req, mem_we, mem_addr, mem_wdata stable from request until ack.
- cont held high before HALT entry: release on first posedge in HALT (one cycle of halt=1).

## Test plan
- Read: ADS with cpu_d_o=0x2A, cpu_addr=0x345; RD_n low; ack after 2 cycles with rdata=0x5C -> mem_addr=0xA345, flags=0x2, mem_we=0, cpu_ce low until DONE, cpu_d_i=0x5C.
- Write: ADS cpu_d_o=0x01, addr=0xFFF; WR_n low with cpu_d_o=0x99; immediate ack -> mem_addr=0x1FFF, mem_wdata=0x99, mem_we=1, cpu_ce low exactly 2 cycles.
- WAIT_STATES=3 read with immediate ack -> DONE 3 cycles after ack, cpu_ce low 5 cycles.
- Halt: ADS cpu_d_o=0x80, read completes -> halt=1, cpu_ce=0 indefinitely; pulse cont -> halt=0, one DONE cycle, IDLE.
- rst_n asserted while mem_req=1 -> mem_req=0 immediately, later ack ignored, all outputs at reset values.
- Spurious mem_ack in IDLE and RD_n+WR_n both low -> no state change from ack; dual strobe issues read only (mem_we=0).
